// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: monitors the multiplexed 8-digit seven-segment bus
// (active-low AN strobes, active-low CA patterns). It waits for each digit
// to settle, decodes the pattern back to a hex nibble, and reassembles the
// 32-bit display word.
// Optional build macro: SEGDEC_DP_IGNORE_EN forces the decimal point (CA[7])
// to 1 before the stability compare and decode.
module seg_scan_decoder #(
    parameter int unsigned SETTLE = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  AN,
    input  logic [7:0]  CA,
    output logic [31:0] value,
    output logic        valid,
    output logic [7:0]  err_mask,
    output logic        busy
);

    localparam logic [7:0] SETTLE_C  = 8'(SETTLE);
    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLING,
        CAPTURED
    } state_t;

    state_t      state, state_d;
    logic [7:0]  an_q, ca_q, an_h, ca_h;
    logic [7:0]  cnt, cnt_d;
    logic        load_h, capture;
    logic [7:0]  an_n;
    logic        blank, changed;
    logic [2:0]  idx;
    logic [3:0]  nib;
    logic        nib_err;
    logic [7:0]  seen, seen_nx;
    logic [31:0] shadow_val, val_nx;
    logic [7:0]  shadow_err, err_nx;

    // Input stage: register the raw bus once
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            an_q <= '1;
            ca_q <= '1;
        end else begin
            an_q <= AN;
`ifdef SEGDEC_DP_IGNORE_EN
            ca_q <= {1'b1, CA[6:0]};
`else
            ca_q <= CA;
`endif
        end
    end

    // Input classification: one-low AN check, change detect, digit index, segment decode
    always_comb begin
        an_n    = ~an_q;
        blank   = !((an_n != '0) && ((an_n & (an_n - 8'd1)) == '0));
        changed = ({an_q, ca_q} != {an_h, ca_h});
        idx     = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!an_h[i]) idx = 3'(i);
        end
        nib     = '0;
        nib_err = 1'b0;
        case (ca_h)
            8'hC0: nib = 4'h0;
            8'hF9: nib = 4'h1;
            8'hA4: nib = 4'h2;
            8'hB0: nib = 4'h3;
            8'h99: nib = 4'h4;
            8'h92: nib = 4'h5;
            8'h82: nib = 4'h6;
            8'hD8: nib = 4'h7;
            8'h80: nib = 4'h8;
            8'h90: nib = 4'h9;
            8'h88: nib = 4'hA;
            8'h83: nib = 4'hB;
            8'hA7: nib = 4'hC;
            8'hA1: nib = 4'hD;
            8'h86: nib = 4'hE;
            8'h8E: nib = 4'hF;
            default: nib_err = 1'b1;
        endcase
    end

    // FSM next-state: settle counting, capture decision, held-pair reload
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        load_h  = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (!blank) begin
                    state_d = SETTLING;
                    cnt_d   = '0;
                    load_h  = 1'b1;
                end
            end
            SETTLING: begin
                if (changed) begin
                    load_h  = 1'b1;
                    cnt_d   = '0;
                    state_d = blank ? IDLE : SETTLING;
                end else if (cnt >= SETTLE_M1) begin
                    // capture fires on the edge where cnt reaches SETTLE
                    capture = 1'b1;
                    cnt_d   = SETTLE_C;
                    state_d = CAPTURED;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            CAPTURED: begin
                if (changed) begin
                    load_h  = 1'b1;
                    cnt_d   = '0;
                    state_d = blank ? IDLE : SETTLING;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register with held pair and settle counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
            an_h  <= '1;
            ca_h  <= '1;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (load_h) begin
                an_h <= an_q;
                ca_h <= ca_q;
            end
        end
    end

    // Shadow frame including the digit being captured this cycle
    always_comb begin
        seen_nx            = seen | (8'd1 << idx);
        val_nx             = shadow_val;
        val_nx[{idx, 2'b00} +: 4] = nib;
        err_nx             = shadow_err;
        err_nx[idx]        = nib_err;
    end

    // Frame assembly: store captured digits, publish when all eight are seen
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow_val <= '0;
            shadow_err <= '0;
            seen       <= '0;
            value      <= '0;
            err_mask   <= '0;
            valid      <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (capture) begin
                shadow_val <= val_nx;
                shadow_err <= err_nx;
                if (seen_nx == 8'hFF) begin
                    value    <= val_nx;
                    err_mask <= err_nx;
                    valid    <= 1'b1;
                    seen     <= '0;
                end else begin
                    seen <= seen_nx;
                end
            end
        end
    end

    assign busy = (seen != '0);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder: table-driven frame scans with a frame
// scoreboard, plus hand-written short-dwell and mid-frame reset sequences.
module tb_seg_scan_decoder;

    localparam int unsigned SETTLE = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [7:0]  AN, CA;
    logic [31:0] value;
    logic        valid;
    logic [7:0]  err_mask;
    logic        busy;

    seg_scan_decoder #(.SETTLE(SETTLE)) dut (
        .CLK(CLK), .RST_N(RST_N), .AN(AN), .CA(CA),
        .value(value), .valid(valid), .err_mask(err_mask), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] exp_val;
        logic [7:0]  exp_err;
    } frame_t;

    typedef struct {
        logic [31:0] word;
        int          ovr_idx;   // -1 none, 8 = all digits
        logic [7:0]  ovr_ca;
        bit          lag;
        logic [31:0] exp_val;
        logic [7:0]  exp_err;
    } vec_t;

    frame_t sb[$];
    int     errors = 0;
    int     checks = 0;
    logic   prev_valid = 1'b0;

    function automatic logic [7:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 8'hC0; 4'h1: seg = 8'hF9; 4'h2: seg = 8'hA4; 4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99; 4'h5: seg = 8'h92; 4'h6: seg = 8'h82; 4'h7: seg = 8'hD8;
            4'h8: seg = 8'h80; 4'h9: seg = 8'h90; 4'hA: seg = 8'h88; 4'hB: seg = 8'h83;
            4'hC: seg = 8'hA7; 4'hD: seg = 8'hA1; 4'hE: seg = 8'h86; default: seg = 8'h8E;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one AN/CA pair for exactly n rising edges
    task automatic drive(input logic [7:0] an, input logic [7:0] ca, input int n);
        AN = an;
        CA = ca;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Scoreboard consumer: every valid pulse must match the oldest expected frame
    always @(negedge CLK) begin
        frame_t f;
        if (valid) begin
            check("valid_gap", {31'd0, prev_valid}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got value %h err %h expected no frame", value, err_mask);
            end else begin
                f = sb.pop_front();
                check("frame_value", value, f.exp_val);
                check("frame_err", {24'd0, err_mask}, {24'd0, f.exp_err});
            end
        end
        prev_valid = valid;
    end

    // Full scan digits 0..7; checks valid arrives exactly one edge after the final settle
    task automatic scan_frame(input logic [7:0] cas [8], input bit lag,
                              input logic [31:0] ev, input logic [7:0] ee);
        logic [7:0] an;
        frame_t f;
        f.exp_val = ev;
        f.exp_err = ee;
        sb.push_back(f);
        for (int i = 0; i < 7; i++) begin
            an = ~(8'd1 << i);
            if (lag && i > 0) begin
                drive(an, cas[i-1], 1);
                drive(an, cas[i], 19);
            end else begin
                drive(an, cas[i], 20);
            end
        end
        if (lag) drive(8'h7F, cas[6], 1);
        drive(8'h7F, cas[7], SETTLE + 1);
        check("valid_early", {31'd0, valid}, 32'd0);
        @(posedge CLK);
        #1;
        check("valid_edge", {31'd0, valid}, 32'd1);
        drive(8'h7F, cas[7], 10);
        drive(8'hFF, 8'hFF, 4);
    endtask

    vec_t       vecs [5];
    logic [7:0] cas [8];
    logic [31:0] w;

    initial begin
        vecs[0] = '{32'h12345678, -1, 8'h00, 1'b0, 32'h12345678, 8'h00};
        vecs[1] = '{32'h12345678, -1, 8'h00, 1'b1, 32'h12345678, 8'h00};
        vecs[2] = '{32'h89ABCDEF,  3, 8'hCA, 1'b0, 32'h89AB0DEF, 8'h08};
`ifdef SEGDEC_DP_IGNORE_EN
        vecs[3] = '{32'h00000000,  8, 8'h40, 1'b0, 32'h00000000, 8'h00};
`else
        vecs[3] = '{32'h00000000,  8, 8'h40, 1'b0, 32'h00000000, 8'hFF};
`endif
        vecs[4] = '{32'h0F1E2D3C, -1, 8'h00, 1'b1, 32'h0F1E2D3C, 8'h00};

        RST_N = 1'b0;
        AN    = 8'hFF;
        CA    = 8'hFF;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_value", value, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_err", {24'd0, err_mask}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        RST_N = 1'b1;
        drive(8'hFF, 8'hFF, 3);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 8; i++) begin
                w = vecs[v].word >> (4 * i);
                cas[i] = seg(w[3:0]);
                if (vecs[v].ovr_idx == i || vecs[v].ovr_idx == 8) cas[i] = vecs[v].ovr_ca;
            end
            scan_frame(cas, vecs[v].lag, vecs[v].exp_val, vecs[v].exp_err);
        end

        // Digit 5 dwells only SETTLE cycles: frame must stay incomplete
        w = 32'hCAFEF00D;
        for (int i = 0; i < 8; i++) begin
            if (i != 5) drive(~(8'd1 << i), seg(4'(w >> (4 * i))), 20);
        end
        drive(8'hDF, seg(4'(w >> 20)), SETTLE);
        drive(8'hFF, 8'hFF, 10);
        check("busy_partial", {31'd0, busy}, 32'd1);
        sb.push_back('{32'hCAFEF00D, 8'h00});
        drive(8'hDF, seg(4'(w >> 20)), 20);
        drive(8'hFF, 8'hFF, 10);

        // Reset mid-frame discards the partial frame
        w = 32'h11112222;
        for (int i = 0; i < 4; i++) drive(~(8'd1 << i), seg(4'(w >> (4 * i))), 20);
        check("busy_mid", {31'd0, busy}, 32'd1);
        RST_N = 1'b0;
        AN    = 8'hFF;
        CA    = 8'hFF;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_value", value, 32'd0);
        check("rst_mid_err", {24'd0, err_mask}, 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        drive(8'hFF, 8'hFF, 3);
        w = 32'hDEADBEEF;
        for (int i = 0; i < 8; i++) cas[i] = seg(4'(w >> (4 * i)));
        scan_frame(cas, 1'b0, 32'hDEADBEEF, 8'h00);

        for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge CLK);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
